// File: rtl/stack_display_writer_if.sv
// Write/strobe handshake between the stack calculator core and stack_display_writer.
// The calculator drives requests through the master modport; wr_ready flows back.
interface stack_display_writer_if;
    logic        wr_valid;
    logic [4:0]  wr_index;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clear;
    logic        commit;

    modport master (
        output wr_valid, wr_index, wr_data, clear, commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_index, wr_data, clear, commit,
        output wr_ready
    );
endinterface

// File: rtl/stack_display_writer.sv
// Shadow image of 24 x 16-bit slots published to the numbers bus at a vsync frame start.
// Define STACK_DISP_IMMEDIATE_EN to publish on the first edge after a commit (tearing possible).
module stack_display_writer #(
    parameter logic [15:0] FILL = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    stack_display_writer_if.slave        wr,
    input  logic                         vga_v_sync,
    output logic [383:0]                 numbers,
    output logic                         frame_done,
    output logic                         bad_index
);
    localparam int         SLOTS = 24;
    localparam logic [4:0] LAST  = 5'd23;

    typedef enum logic [1:0] {IDLE, CLEAR, ARMED} state_t;

    state_t                      state_reg, state_next;
    logic [4:0]                  cnt_reg, cnt_next;
    logic                        vs_q;
    logic                        frame_done_reg, frame_done_next;
    logic                        bad_index_reg, bad_index_next;
    logic [SLOTS-1:0][15:0]      shadow_reg, shadow_next;
    logic [SLOTS-1:0][15:0]      numbers_reg;
    logic                        wr_ready_int;
    logic                        wr_en, clr_en, copy_en, frame_start;

`ifdef STACK_DISP_IMMEDIATE_EN
    assign frame_start = 1'b1;
`else
    // Falling edge of the active-low vsync marks the start of a new frame.
    assign frame_start = vs_q & ~vga_v_sync;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        wr_ready_int    = 1'b0;
        wr_en           = 1'b0;
        clr_en          = 1'b0;
        copy_en         = 1'b0;
        frame_done_next = 1'b0;
        bad_index_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                wr_ready_int = 1'b1;
                if (wr.clear) begin
                    state_next = CLEAR;
                    cnt_next   = 5'd0;
                end else if (wr.commit) begin
                    state_next = ARMED;
                end else if (wr.wr_valid) begin
                    if (wr.wr_index <= LAST) wr_en = 1'b1;
                    else                     bad_index_next = 1'b1;
                end
            end
            CLEAR: begin
                clr_en   = 1'b1;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = 5'd0;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    copy_en         = 1'b1;
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-slot next value: a host write and the clear sweep never coincide.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign shadow_next[gi] =
                (wr_en  && wr.wr_index == 5'(gi)) ? wr.wr_data :
                (clr_en && cnt_reg     == 5'(gi)) ? FILL       :
                                                    shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 5'd0;
            vs_q           <= 1'b1;
            frame_done_reg <= 1'b0;
            bad_index_reg  <= 1'b0;
            shadow_reg     <= {SLOTS{FILL}};
            numbers_reg    <= {SLOTS{FILL}};
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            vs_q           <= vga_v_sync;
            frame_done_reg <= frame_done_next;
            bad_index_reg  <= bad_index_next;
            shadow_reg     <= shadow_next;
            if (copy_en) numbers_reg <= shadow_reg;
        end
    end

    assign wr.wr_ready = wr_ready_int;
    assign numbers     = numbers_reg;
    assign frame_done  = frame_done_reg;
    assign bad_index   = bad_index_reg;
endmodule

// File: tb/tb_stack_display_writer.sv
// Directed bench for stack_display_writer: an image-level model checked every cycle,
// plus literal expectations from the test plan.
module tb_stack_display_writer;
    localparam logic [15:0] FILL = 16'h1904;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         vga_v_sync = 1'b1;
    logic [383:0] numbers;
    logic         frame_done;
    logic         bad_index;

    stack_display_writer_if wr();

    stack_display_writer #(.FILL(FILL)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr.slave),
        .vga_v_sync (vga_v_sync),
        .numbers    (numbers),
        .frame_done (frame_done),
        .bad_index  (bad_index)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int bad_cnt = 0;
    int rdy_low_cnt = 0;

    // Behavioural model: the whole shadow becomes FILL the moment a clear is taken,
    // and the busy time is just a countdown.
    logic [15:0] m_shadow  [24];
    logic [15:0] m_numbers [24];
    int          m_busy;
    bit          m_armed;
    bit          m_prev_vs;
    bit          m_fd;
    bit          m_bad;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [383:0] model_image();
        logic [383:0] r;
        for (int i = 0; i < 24; i++) r[16*i +: 16] = m_numbers[i];
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 24; i++) begin
                m_shadow[i]  = FILL;
                m_numbers[i] = FILL;
            end
            m_busy = 0; m_armed = 0; m_prev_vs = 1; m_fd = 0; m_bad = 0;
        end else begin
            m_fd = 0;
            m_bad = 0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (m_armed) begin
`ifdef STACK_DISP_IMMEDIATE_EN
                if (1'b1) begin
`else
                if (m_prev_vs && !vga_v_sync) begin
`endif
                    for (int i = 0; i < 24; i++) m_numbers[i] = m_shadow[i];
                    m_armed = 0;
                    m_fd = 1;
                end
            end else begin
                if (wr.clear) begin
                    for (int i = 0; i < 24; i++) m_shadow[i] = FILL;
                    m_busy = 24;
                end else if (wr.commit) begin
                    m_armed = 1;
                end else if (wr.wr_valid) begin
                    if (int'(wr.wr_index) < 24) m_shadow[wr.wr_index] = wr.wr_data;
                    else m_bad = 1;
                end
            end
            m_prev_vs = vga_v_sync;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("wr_ready",   384'(wr.wr_ready), 384'(m_busy == 0 && !m_armed));
            chk("frame_done", 384'(frame_done),  384'(m_fd));
            chk("bad_index",  384'(bad_index),   384'(m_bad));
            chk("numbers",    numbers,           model_image());
            fd_cnt  += int'(frame_done);
            bad_cnt += int'(bad_index);
            if (!wr.wr_ready) rdy_low_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [15:0] data);
        @(negedge clk);
        wr.wr_valid = 1'b1; wr.wr_index = idx; wr.wr_data = data;
        @(negedge clk);
        wr.wr_valid = 1'b0;
        $display("write idx=%0d data=%h", idx, data);
    endtask

    task automatic strobe(input logic c, input logic m);
        @(negedge clk);
        wr.clear = c; wr.commit = m;
        @(negedge clk);
        wr.clear = 1'b0; wr.commit = 1'b0;
        $display("strobe clear=%0b commit=%0b", c, m);
    endtask

    task automatic sync_pulse();
        vga_v_sync = 1'b0;
        idle(3);
        vga_v_sync = 1'b1;
        idle(2);
    endtask

    logic [383:0] all_fill;
    logic [383:0] exp_img;
    int fd0, b0, r0, n;

    initial begin
        all_fill = {24{FILL}};
        wr.wr_valid = 1'b0; wr.wr_index = '0; wr.wr_data = '0;
        wr.clear = 1'b0; wr.commit = 1'b0;

        #12;
        chk("reset_numbers", numbers, all_fill);
        chk("reset_ready",   384'(wr.wr_ready), 384'(1));
        chk("reset_pulses",  384'({frame_done, bad_index}), 384'(0));
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Write two boundary slots, commit, then one vsync falling edge.
        fd0 = fd_cnt;
        do_write(5'd0, 16'h0007);
        do_write(5'd23, 16'hABCD);
        strobe(1'b0, 1'b1);
        idle(3);
`ifndef STACK_DISP_IMMEDIATE_EN
        chk("pre_edge_numbers", numbers, all_fill);
`endif
        vga_v_sync = 1'b0;
        idle(3);
        chk("fd_one_pulse", 384'(fd_cnt - fd0), 384'(1));
        chk("slot0",  384'(numbers[15:0]),    384'(16'h0007));
        chk("slot23", 384'(numbers[383:368]), 384'(16'hABCD));
        vga_v_sync = 1'b1;
        idle(2);
        $display("commit frame_done pulses=%0d", fd_cnt - fd0);

        // Out-of-range index: one bad_index pulse, no slot touched.
        b0 = bad_cnt;
        do_write(5'd24, 16'hFFFF);
        idle(1);
        chk("bad_one_pulse", 384'(bad_cnt - b0), 384'(1));
        exp_img = all_fill;
        exp_img[15:0]    = 16'h0007;
        exp_img[383:368] = 16'hABCD;
        strobe(1'b0, 1'b1);
        sync_pulse();
        chk("bad_no_change", numbers, exp_img);

        // Clear wins over a same-cycle commit.
        r0 = rdy_low_cnt;
        fd0 = fd_cnt;
        strobe(1'b1, 1'b1);
        n = 0;
        while (!wr.wr_ready && n < 100) begin
            idle(1);
            n++;
        end
        chk("clear_ready_low", 384'(rdy_low_cnt - r0), 384'(24));
        chk("commit_dropped",  384'(fd_cnt - fd0),     384'(0));
        $display("clear busy cycles=%0d", rdy_low_cnt - r0);
        strobe(1'b0, 1'b1);
        sync_pulse();
        chk("after_clear", numbers, all_fill);

        // Commit while vsync already low waits for a full 0->1->0; writes in ARMED ignored.
        do_write(5'd5, 16'h1111);
        vga_v_sync = 1'b0;
        idle(2);
        strobe(1'b0, 1'b1);
        idle(4);
        do_write(5'd5, 16'h2222);
        idle(2);
`ifndef STACK_DISP_IMMEDIATE_EN
        chk("armed_low_hold", 384'(numbers[95:80]), 384'(FILL));
`endif
        vga_v_sync = 1'b1;
        idle(2);
        vga_v_sync = 1'b0;
        idle(2);
        chk("armed_slot5", 384'(numbers[95:80]), 384'(16'h1111));
        vga_v_sync = 1'b1;
        idle(2);

        // Asynchronous reset in the middle of a clear sweep (cnt = 10).
        strobe(1'b1, 1'b0);
        idle(10);
        #2 reset = 1'b0;
        #1;
        chk("async_numbers", numbers, all_fill);
        chk("async_ready",   384'(wr.wr_ready), 384'(1));
        chk("async_pulses",  384'({frame_done, bad_index}), 384'(0));
        $display("async reset mid-clear numbers=%h", numbers[95:80]);
        @(negedge clk);
        reset = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_display_writer.md
# stack_display_writer

Producer side of the 384-bit `numbers` display bus consumed by `picture_generator`. It holds a 24-slot × 16-bit shadow image written by the stack calculator core, clears it on request, and commits it to the live `numbers` bus only at a VGA frame boundary, so the display never tears mid-frame. It sits in the `clk_25` domain between the calculator datapath and `picture_generator`.

## Interface
- `FILL`, 16'h0000, value written into every slot by reset and by clear.
- `clk` input 1: pixel clock (`clk_25`); all logic on the rising edge.
- `reset` input 1: asynchronous, active-low; forces the reset state immediately.
- `wr_valid` input 1: write request.
- `wr_index` input 5: slot 0..23; slot k occupies `numbers[16k+15:16k]`.
- `wr_data` input 16: slot value.
- `wr_ready` output 1: writes, clears and commits are accepted only while high.
- `clear` input 1: strobe, fill all shadow slots with `FILL`.
- `commit` input 1: strobe, publish shadow to `numbers` at the next frame start.
- `vga_v_sync` input 1: active-low vertical sync from `picture_generator`.
- `numbers` output 384: live display image.
- `frame_done` output 1: one-cycle pulse after `numbers` is updated.
- `bad_index` output 1: one-cycle pulse when an accepted write has `wr_index` > 23.

## Operation
- Reset: shadow and `numbers` hold `FILL` replicated 24 times, state IDLE, `wr_ready`=1, `frame_done`=0, `bad_index`=0, sync history register `vs_q`=1.
- FSM states: IDLE, CLEAR, ARMED.
- IDLE, `wr_ready`=1. Priority within one cycle: `clear` > `commit` > write. Lower-priority requests in the same cycle are dropped.
  - `clear` goes to CLEAR with sweep counter 0.
  - `commit` goes to ARMED.
  - `wr_valid` with index 0..23 writes `wr_data` into that shadow slot. Index 24..31 writes nothing and pulses `bad_index`.
- CLEAR, `wr_ready`=0. Each cycle writes `FILL` to slot `cnt` and increments `cnt`. At `cnt`=23, after writing that slot, it returns to IDLE.
- ARMED, `wr_ready`=0. The shadow is frozen.
  - The frame start is `vs_q`=1 and `vga_v_sync`=0.
  - At frame start, `numbers` gets the shadow, the state returns to IDLE, and `frame_done` pulses.
- Strobes and writes presented while `wr_ready`=0 are ignored. They are not queued.
- `vs_q` samples `vga_v_sync` every cycle in every state. An edge that falls during IDLE or CLEAR is not remembered.
- `numbers` changes only on a commit copy or on reset.

## Timing
- Write: accepted at edge T; the shadow slot is updated at T. `numbers` is not affected.
- `bad_index` is high for the cycle following T.
- Clear: accepted at T; `wr_ready` is low for 24 cycles; `wr_ready`=1 again after edge T+24.
- Commit: accepted at T; ARMED from T.
  - If `vga_v_sync` was high at T and is sampled low at edge E > T, then at E: `numbers` is updated, the state is IDLE, and `frame_done`=1 for the cycle after E.
  - If `vga_v_sync` is already low at T, the commit waits for the following frame.
- Reset asserted mid-CLEAR or mid-ARMED: immediate return to the reset state. Any pending commit is lost, and `numbers` returns to `FILL`.
- `frame_done` and `bad_index` are registered outputs and are never high in the same cycle.

## Configuration
- `STACK_DISP_IMMEDIATE_EN` defined:
  - ARMED ignores `vga_v_sync` and copies on the first edge after entry. `numbers` updates at T+1 and `frame_done` pulses after T+1.
  - Tearing is possible. This mode is intended for simulation and fast bring-up.
- Not defined: frame-synchronous commit as described above.

## Test plan
- Reset with `FILL`=16'h1904: `numbers` = 384'h1904…1904 (24 copies), `wr_ready`=1, both pulses low.
- Write slot 0 = 16'h0007 and slot 23 = 16'hABCD, then commit, then drive `vga_v_sync` 1→0:
  - `numbers` is unchanged before the edge.
  - After the edge, `numbers[15:0]`=0007, `numbers[383:368]`=ABCD, and there is one `frame_done` pulse.
- Write with `wr_index`=24: one `bad_index` pulse. After commit, all slots are unchanged.
- `clear` and `commit` asserted in the same cycle: CLEAR runs with `wr_ready` low for exactly 24 cycles and the commit is dropped. A later commit plus sync edge gives all slots = `FILL`.
- ARMED while `vga_v_sync` is held low: no update until a 0→1→0 sequence. A write attempted during ARMED is ignored and the shadow keeps its pre-commit contents.
- `reset` pulsed low mid-CLEAR at `cnt`=10: outputs return to reset values at once, with no clock required.
